// File: rtl/nvdla_dbb_stream_bridge_if.sv
// DBB request/data/response channels plus HWPE streamer control and stream channels.
// master = NVDLA core + HWPE streamer side, slave = the bridge.
interface nvdla_dbb_stream_bridge_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 8,
    parameter int LEN_W  = 4
) ();
    logic                  wr_req_valid_i, wr_req_ready_o;
    logic [ADDR_W-1:0]     wr_req_addr_i;
    logic [LEN_W-1:0]      wr_req_len_i;
    logic [ID_W-1:0]       wr_req_id_i;
    logic                  wr_data_valid_i, wr_data_ready_o;
    logic [DATA_W-1:0]     wr_data_i;
    logic [DATA_W/8-1:0]   wr_strb_i;
    logic                  wr_last_i;
    logic                  wr_rsp_valid_o, wr_rsp_ready_i;
    logic [ID_W-1:0]       wr_rsp_id_o;
    logic                  wr_rsp_err_o;
    logic                  rd_req_valid_i, rd_req_ready_o;
    logic [ADDR_W-1:0]     rd_req_addr_i;
    logic [LEN_W-1:0]      rd_req_len_i;
    logic [ID_W-1:0]       rd_req_id_i;
    logic                  rd_data_valid_o, rd_data_ready_i;
    logic [DATA_W-1:0]     rd_data_o;
    logic [ID_W-1:0]       rd_data_id_o;
    logic                  rd_data_last_o;
    logic                  wr_strm_req_start_o, wr_strm_ready_start_i;
    logic                  rd_strm_req_start_o, rd_strm_ready_start_i;
    logic [ADDR_W-1:0]     strm_base_addr_o;
    logic [LEN_W:0]        strm_trans_size_o;
    logic                  strm_o_valid, strm_o_ready;
    logic [DATA_W-1:0]     strm_o_data;
    logic [DATA_W/8-1:0]   strm_o_strb;
    logic                  strm_i_valid, strm_i_ready;
    logic [DATA_W-1:0]     strm_i_data;

    modport master (
        output wr_req_valid_i, wr_req_addr_i, wr_req_len_i, wr_req_id_i,
        output wr_data_valid_i, wr_data_i, wr_strb_i, wr_last_i, wr_rsp_ready_i,
        output rd_req_valid_i, rd_req_addr_i, rd_req_len_i, rd_req_id_i, rd_data_ready_i,
        output wr_strm_ready_start_i, rd_strm_ready_start_i, strm_o_ready, strm_i_valid, strm_i_data,
        input  wr_req_ready_o, wr_data_ready_o, wr_rsp_valid_o, wr_rsp_id_o, wr_rsp_err_o,
        input  rd_req_ready_o, rd_data_valid_o, rd_data_o, rd_data_id_o, rd_data_last_o,
        input  wr_strm_req_start_o, rd_strm_req_start_o, strm_base_addr_o, strm_trans_size_o,
        input  strm_o_valid, strm_o_data, strm_o_strb, strm_i_ready
    );

    modport slave (
        input  wr_req_valid_i, wr_req_addr_i, wr_req_len_i, wr_req_id_i,
        input  wr_data_valid_i, wr_data_i, wr_strb_i, wr_last_i, wr_rsp_ready_i,
        input  rd_req_valid_i, rd_req_addr_i, rd_req_len_i, rd_req_id_i, rd_data_ready_i,
        input  wr_strm_ready_start_i, rd_strm_ready_start_i, strm_o_ready, strm_i_valid, strm_i_data,
        output wr_req_ready_o, wr_data_ready_o, wr_rsp_valid_o, wr_rsp_id_o, wr_rsp_err_o,
        output rd_req_ready_o, rd_data_valid_o, rd_data_o, rd_data_id_o, rd_data_last_o,
        output wr_strm_req_start_o, rd_strm_req_start_o, strm_base_addr_o, strm_trans_size_o,
        output strm_o_valid, strm_o_data, strm_o_strb, strm_i_ready
    );
endinterface

// File: rtl/nvdla_dbb_stream_bridge.sv
// DBB read/write bursts -> HWPE streamer jobs, one burst at a time, round-robin arbitration.
// Optional: NVDLA_DBB_BRIDGE_LAST_CHECK_EN flags wr_last_i vs beat-count mismatches in wr_rsp_err_o.
module nvdla_dbb_stream_bridge #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 8,
    parameter int LEN_W  = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    nvdla_dbb_stream_bridge_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, W_DATA, W_DRAIN, W_RESP, R_DATA, R_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [LEN_W:0]    cnt_q, cnt_d;
    logic [LEN_W-1:0]  len_q, grant_len;
    logic [ID_W-1:0]   id_q;
    logic              last_rd_q;
    logic              wr_elig, rd_elig, grant_wr, grant_rd, wr_hs, at_last;

    assign wr_elig   = bus.wr_req_valid_i && bus.wr_strm_ready_start_i;
    assign rd_elig   = bus.rd_req_valid_i && bus.rd_strm_ready_start_i;
    assign at_last   = (cnt_q == {1'b0, len_q});
    assign grant_len = grant_wr ? bus.wr_req_len_i : bus.rd_req_len_i;

    assign bus.strm_o_data  = bus.wr_data_i;
    assign bus.strm_o_strb  = bus.wr_strb_i;
    assign bus.rd_data_o    = bus.strm_i_data;
    assign bus.rd_data_id_o = id_q;
    assign bus.wr_rsp_id_o  = id_q;

    always_comb begin
        state_d                 = state_q;
        cnt_d                   = cnt_q;
        grant_wr                = 1'b0;
        grant_rd                = 1'b0;
        wr_hs                   = 1'b0;
        bus.wr_req_ready_o      = 1'b0;
        bus.rd_req_ready_o      = 1'b0;
        bus.wr_strm_req_start_o = 1'b0;
        bus.rd_strm_req_start_o = 1'b0;
        bus.wr_data_ready_o     = 1'b0;
        bus.strm_o_valid        = 1'b0;
        bus.wr_rsp_valid_o      = 1'b0;
        bus.rd_data_valid_o     = 1'b0;
        bus.rd_data_last_o      = 1'b0;
        bus.strm_i_ready        = 1'b0;
        if (clear_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // On contention the side opposite the last grant wins.
                    grant_wr                = wr_elig && (!rd_elig || last_rd_q);
                    grant_rd                = rd_elig && !grant_wr;
                    bus.wr_req_ready_o      = grant_wr;
                    bus.wr_strm_req_start_o = grant_wr;
                    bus.rd_req_ready_o      = grant_rd;
                    bus.rd_strm_req_start_o = grant_rd;
                    cnt_d                   = '0;
                    if (grant_wr)      state_d = W_DATA;
                    else if (grant_rd) state_d = R_DATA;
                end
                W_DATA: begin
                    bus.strm_o_valid    = bus.wr_data_valid_i;
                    bus.wr_data_ready_o = bus.strm_o_ready;
                    wr_hs               = bus.wr_data_valid_i && bus.strm_o_ready;
                    if (wr_hs) begin
                        cnt_d = cnt_q + {{LEN_W{1'b0}}, 1'b1};
                        if (at_last) state_d = W_DRAIN;
                    end
                end
                W_DRAIN: if (bus.wr_strm_ready_start_i) state_d = W_RESP;
                W_RESP: begin
                    bus.wr_rsp_valid_o = 1'b1;
                    if (bus.wr_rsp_ready_i) state_d = IDLE;
                end
                R_DATA: begin
                    bus.rd_data_valid_o = bus.strm_i_valid;
                    bus.strm_i_ready    = bus.rd_data_ready_i;
                    bus.rd_data_last_o  = at_last;
                    if (bus.strm_i_valid && bus.rd_data_ready_i) begin
                        cnt_d = cnt_q + {{LEN_W{1'b0}}, 1'b1};
                        if (at_last) state_d = R_DRAIN;
                    end
                end
                R_DRAIN: if (bus.rd_strm_ready_start_i) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q               <= IDLE;
            cnt_q                 <= '0;
            len_q                 <= '0;
            id_q                  <= '0;
            last_rd_q             <= 1'b1;
            bus.strm_base_addr_o  <= '0;
            bus.strm_trans_size_o <= '0;
        end else if (clear_i) begin
            state_q               <= IDLE;
            cnt_q                 <= '0;
            len_q                 <= '0;
            id_q                  <= '0;
            last_rd_q             <= 1'b1;
            bus.strm_base_addr_o  <= '0;
            bus.strm_trans_size_o <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (grant_wr || grant_rd) begin
                len_q                 <= grant_len;
                id_q                  <= grant_wr ? bus.wr_req_id_i : bus.rd_req_id_i;
                last_rd_q             <= grant_rd;
                bus.strm_base_addr_o  <= grant_wr ? bus.wr_req_addr_i : bus.rd_req_addr_i;
                bus.strm_trans_size_o <= {1'b0, grant_len} + {{LEN_W{1'b0}}, 1'b1};
            end
        end
    end

`ifdef NVDLA_DBB_BRIDGE_LAST_CHECK_EN
    logic err_q;

    // Sticky across the burst; completion still follows the beat count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                     err_q <= 1'b0;
        else if (clear_i)                err_q <= 1'b0;
        else if (grant_wr || grant_rd)   err_q <= 1'b0;
        else if (wr_hs && (bus.wr_last_i != at_last)) err_q <= 1'b1;
    end

    assign bus.wr_rsp_err_o = err_q;
`else
    logic unused_last;
    assign unused_last      = bus.wr_last_i;
    assign bus.wr_rsp_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_nvdla_dbb_stream_bridge.sv
// Bench for nvdla_dbb_stream_bridge: directed vector table plus randomized bursts vs a burst-level model.
module tb_nvdla_dbb_stream_bridge;
    logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
    int   n_cmp = 0, n_mis = 0;

    always #5 clk = ~clk;

    nvdla_dbb_stream_bridge_if #(.DATA_W(64), .ADDR_W(32), .ID_W(8), .LEN_W(4)) b ();

    nvdla_dbb_stream_bridge #(.DATA_W(64), .ADDR_W(32), .ID_W(8), .LEN_W(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .bus(b.slave)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [7:0]  id;
        int          last_at;
        bit          rnd;
        int          clr_at;
        bit          contend;
        logic [4:0]  exp_size;
        bit          exp_err;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_mis++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    task automatic wr_burst(input vec_t v);
        int i, cyc;
        logic vv, rr, exp_err;
        logic [63:0] d;
        logic [7:0]  s;
        exp_err = 1'b0;
`ifdef NVDLA_DBB_BRIDGE_LAST_CHECK_EN
        exp_err = v.exp_err;
`endif
        @(negedge clk);
        b.wr_req_valid_i = 1; b.wr_req_addr_i = v.addr; b.wr_req_len_i = v.len; b.wr_req_id_i = v.id;
        b.wr_strm_ready_start_i = 1; b.rd_strm_ready_start_i = 1;
        if (v.contend) b.rd_req_valid_i = 1;
        #1; cyc = 0;
        while (!b.wr_req_ready_o) begin
            if (++cyc > 20) begin timeout("wr_grant"); b.wr_req_valid_i = 0; b.rd_req_valid_i = 0; return; end
            @(negedge clk); #1;
        end
        check("wr_start", b.wr_strm_req_start_o, 1);
        if (v.contend) check("arb_rd_held", {b.rd_req_ready_o, b.rd_strm_req_start_o}, 0);
        @(negedge clk);
        b.wr_req_valid_i = 0; b.rd_req_valid_i = 0; b.wr_strm_ready_start_i = 0;
        #1;
        check("wr_start_pulse", b.wr_strm_req_start_o, 0);
        check("wr_base", b.strm_base_addr_o, v.addr);
        check("wr_size", b.strm_trans_size_o, v.exp_size);
        i = 0; cyc = 0;
        while (i <= int'(v.len)) begin
            if (i == v.clr_at) begin
                clear = 1; b.wr_data_valid_i = 1; b.strm_o_ready = 1;
                @(negedge clk); clear = 0; #1;
                check("clr_idle", {b.wr_data_ready_o, b.strm_o_valid}, 0);
                check("clr_base", b.strm_base_addr_o, 0);
                b.wr_data_valid_i = 0; b.wr_strm_ready_start_i = 1; b.wr_rsp_ready_i = 1;
                repeat (4) begin @(negedge clk); #1; check("clr_no_rsp", b.wr_rsp_valid_o, 0); end
                b.wr_rsp_ready_i = 0;
                return;
            end
            vv = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            rr = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            d  = {$urandom, $urandom};
            s  = 8'($urandom);
            b.wr_data_valid_i = vv; b.strm_o_ready = rr; b.wr_data_i = d; b.wr_strb_i = s;
            b.wr_last_i = (i == v.last_at);
            #1;
            check("wr_pass_hs", {b.strm_o_valid, b.wr_data_ready_o}, {vv, rr});
            if (vv && rr) begin
                check("wr_data", b.strm_o_data, d);
                check("wr_strb", b.strm_o_strb, s);
                i++;
            end
            @(negedge clk);
            if (++cyc > 400) begin timeout("wr_beats"); return; end
        end
        // surplus beat must stall while the streamer drains
        b.wr_data_valid_i = 1; b.strm_o_ready = 1; b.wr_last_i = 0;
        #1;
        check("wr_drain_stall", {b.wr_data_ready_o, b.strm_o_valid, b.wr_rsp_valid_o}, 0);
        @(negedge clk); #1;
        check("wr_drain_wait", b.wr_rsp_valid_o, 0);
        b.wr_data_valid_i = 0; b.wr_strm_ready_start_i = 1;
        cyc = 0;
        @(negedge clk); #1;
        while (!b.wr_rsp_valid_o) begin
            if (++cyc > 10) begin timeout("wr_rsp"); return; end
            @(negedge clk); #1;
        end
        check("wr_rsp_id", b.wr_rsp_id_o, v.id);
        check("wr_rsp_err", b.wr_rsp_err_o, exp_err);
        @(negedge clk); #1;
        check("wr_rsp_hold", b.wr_rsp_valid_o, 1);
        b.wr_rsp_ready_i = 1;
        @(negedge clk); b.wr_rsp_ready_i = 0; #1;
        check("wr_rsp_done", b.wr_rsp_valid_o, 0);
    endtask

    task automatic rd_burst(input vec_t v);
        int i, cyc;
        logic vv, rr;
        logic [63:0] d;
        @(negedge clk);
        b.rd_req_valid_i = 1; b.rd_req_addr_i = v.addr; b.rd_req_len_i = v.len; b.rd_req_id_i = v.id;
        b.wr_strm_ready_start_i = 1; b.rd_strm_ready_start_i = 1;
        if (v.contend) b.wr_req_valid_i = 1;
        #1; cyc = 0;
        while (!b.rd_req_ready_o) begin
            if (++cyc > 20) begin timeout("rd_grant"); b.rd_req_valid_i = 0; b.wr_req_valid_i = 0; return; end
            @(negedge clk); #1;
        end
        check("rd_start", b.rd_strm_req_start_o, 1);
        if (v.contend) check("arb_wr_held", {b.wr_req_ready_o, b.wr_strm_req_start_o}, 0);
        @(negedge clk);
        b.rd_req_valid_i = 0; b.wr_req_valid_i = 0; b.rd_strm_ready_start_i = 0;
        #1;
        check("rd_start_pulse", b.rd_strm_req_start_o, 0);
        check("rd_base", b.strm_base_addr_o, v.addr);
        check("rd_size", b.strm_trans_size_o, v.exp_size);
        i = 0; cyc = 0;
        while (i <= int'(v.len)) begin
            vv = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            rr = v.rnd ? (cyc % 2 == 1) : 1'b1;
            d  = {$urandom, $urandom};
            b.strm_i_valid = vv; b.rd_data_ready_i = rr; b.strm_i_data = d;
            #1;
            check("rd_pass_hs", {b.rd_data_valid_o, b.strm_i_ready}, {vv, rr});
            check("rd_last", b.rd_data_last_o, (i == int'(v.len)));
            if (vv && rr) begin
                check("rd_data", b.rd_data_o, d);
                check("rd_id", b.rd_data_id_o, v.id);
                i++;
            end
            @(negedge clk);
            if (++cyc > 400) begin timeout("rd_beats"); return; end
        end
        b.strm_i_valid = 1; b.rd_data_ready_i = 1;
        #1;
        check("rd_drain_stall", {b.strm_i_ready, b.rd_data_valid_o}, 0);
        @(negedge clk);
        b.strm_i_valid = 0; b.rd_strm_ready_start_i = 1;
        @(negedge clk);
    endtask

    vec_t vt[8];
    vec_t r;

    initial begin
        b.wr_req_valid_i = 0; b.wr_req_addr_i = 0; b.wr_req_len_i = 0; b.wr_req_id_i = 0;
        b.wr_data_valid_i = 0; b.wr_data_i = 0; b.wr_strb_i = 0; b.wr_last_i = 0; b.wr_rsp_ready_i = 0;
        b.rd_req_valid_i = 0; b.rd_req_addr_i = 0; b.rd_req_len_i = 0; b.rd_req_id_i = 0;
        b.rd_data_ready_i = 0; b.wr_strm_ready_start_i = 0; b.rd_strm_ready_start_i = 0;
        b.strm_o_ready = 0; b.strm_i_valid = 0; b.strm_i_data = 0;

        //          wr    addr      len  id     last rnd clr contend size err
        vt[0] = '{1'b1, 32'h300, 4'd1, 8'h22, 1, 1'b0, -1, 1'b1, 5'd2, 1'b0};
        vt[1] = '{1'b0, 32'h400, 4'd2, 8'h33, 0, 1'b0, -1, 1'b1, 5'd3, 1'b0};
        vt[2] = '{1'b1, 32'h100, 4'd3, 8'h5A, 3, 1'b0, -1, 1'b0, 5'd4, 1'b0};
        vt[3] = '{1'b0, 32'h200, 4'd0, 8'h11, 0, 1'b0, -1, 1'b0, 5'd1, 1'b0};
        vt[4] = '{1'b1, 32'h500, 4'd1, 8'h44, 0, 1'b0, -1, 1'b0, 5'd2, 1'b1};
        vt[5] = '{1'b0, 32'h600, 4'd7, 8'h77, 0, 1'b1, -1, 1'b0, 5'd8, 1'b0};
        vt[6] = '{1'b1, 32'h700, 4'd5, 8'h66, 5, 1'b0,  3, 1'b0, 5'd6, 1'b0};
        vt[7] = '{1'b0, 32'h800, 4'd2, 8'h88, 0, 1'b1, -1, 1'b0, 5'd3, 1'b0};

        repeat (3) @(negedge clk);
        rst_n = 1;
        b.wr_data_valid_i = 1; b.strm_o_ready = 1; b.strm_i_valid = 1; b.rd_data_ready_i = 1;
        #1;
        check("rst_wr_side", {b.wr_req_ready_o, b.wr_data_ready_o, b.strm_o_valid, b.wr_rsp_valid_o, b.wr_strm_req_start_o}, 0);
        check("rst_rd_side", {b.rd_req_ready_o, b.rd_data_valid_o, b.strm_i_ready, b.rd_data_last_o, b.rd_strm_req_start_o}, 0);
        check("rst_base", b.strm_base_addr_o, 0);
        check("rst_size", b.strm_trans_size_o, 0);
        b.wr_data_valid_i = 0; b.strm_o_ready = 0; b.strm_i_valid = 0; b.rd_data_ready_i = 0;

        for (int k = 0; k < 8; k++) begin
            if (vt[k].wr) wr_burst(vt[k]);
            else          rd_burst(vt[k]);
        end

        // Burst-level model: size is beats, err means the last flag was not on beat len.
        for (int k = 0; k < 24; k++) begin
            r.wr       = 1'($urandom_range(0, 1));
            r.len      = 4'($urandom_range(0, 15));
            r.addr     = $urandom & 32'hFFFF_FFF8;
            r.id       = 8'($urandom);
            r.last_at  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(r.len) + 1)) : int'(r.len);
            r.rnd      = 1'b1;
            r.clr_at   = -1;
            r.contend  = 1'b0;
            r.exp_size = 5'(int'(r.len) + 1);
            r.exp_err  = (r.last_at != int'(r.len));
            if (r.wr) wr_burst(r);
            else      rd_burst(r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/nvdla_dbb_stream_bridge.md
Name: nvdla_dbb_stream_bridge

Overview:
Parametrised successor of the single-burst DBB-to-HWPE adapter. It converts NVDLA DBB read/write bursts (request, data and response channels) into HWPE streamer jobs, one burst at a time. Read and write requests are arbitrated round-robin. Data is passed beat-by-beat between the DBB side and the HWPE streams. The block sits between the NVDLA core's DBB master port and the HWPE streamer/TCDM interface.

Parameters:
DATA_W, 64, data beat width in bits (multiple of 8)
ADDR_W, 32, byte address width
ID_W, 8, transaction ID width
LEN_W, 4, burst length field width; field value = beats-1 (max 2^LEN_W beats)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; one clock; reset is asynchronous and active-low
clear_i  in  1  synchronous soft clear
wr_req_valid_i / wr_req_ready_o  in/out  1  write request handshake
wr_req_addr_i  in  ADDR_W  write base byte address
wr_req_len_i  in  LEN_W  write beats-1
wr_req_id_i  in  ID_W  write ID
wr_data_valid_i / wr_data_ready_o  in/out  1  write data handshake
wr_data_i  in  DATA_W  write data
wr_strb_i  in  DATA_W/8  byte strobes
wr_last_i  in  1  last write beat marker
wr_rsp_valid_o / wr_rsp_ready_i  out/in  1  write response handshake
wr_rsp_id_o  out  ID_W  response ID
wr_rsp_err_o  out  1  response error
rd_req_valid_i / rd_req_ready_o  in/out  1  read request handshake
rd_req_addr_i, rd_req_len_i, rd_req_id_i  in  ADDR_W/LEN_W/ID_W  read request fields
rd_data_valid_o / rd_data_ready_i  out/in  1  read data handshake
rd_data_o  out  DATA_W  read data
rd_data_id_o  out  ID_W  read ID
rd_data_last_o  out  1  last read beat
wr_strm_req_start_o / wr_strm_ready_start_i  out/in  1  write streamer start / idle
rd_strm_req_start_o / rd_strm_ready_start_i  out/in  1  read streamer start / idle
strm_base_addr_o  out  ADDR_W  job base address (registered)
strm_trans_size_o  out  LEN_W+1  job words = len+1 (registered)
strm_o_valid / strm_o_ready  out/in  1  outgoing write-data stream handshake
strm_o_data, strm_o_strb  out  DATA_W, DATA_W/8  outgoing stream payload
strm_i_valid / strm_i_ready  in/out  1  incoming read-data stream handshake
strm_i_data  in  DATA_W  incoming stream payload

Behaviour:
- Reset/clear: state IDLE, beat counter 0, fairness bit = "last grant read", err flag 0. All valid/ready/start outputs 0. Registered addr/size/id are 0.
- States: IDLE, W_DATA, W_DRAIN, W_RESP, R_DATA, R_DRAIN.
- IDLE:
  - A request is eligible when its valid is 1 and its streamer's ready_start is 1.
  - If exactly one is eligible, it wins. If both are eligible, the one opposite the fairness bit wins.
  - Winner, in the same cycle: req_ready_o=1, matching req_start_o=1 (one-cycle pulse). Latch addr, len and id; update the fairness bit; counter=0.
  - Next state is W_DATA (write winner) or R_DATA (read winner).
- W_DATA:
  - strm_o_valid=wr_data_valid_i and wr_data_ready_o=strm_o_ready. Data and strb pass through combinationally.
  - Each handshake increments the counter. The handshake at counter==len goes to W_DRAIN.
  - wr_data_ready_o=0 in every other state, so surplus beats stall.
- W_DRAIN: wait for wr_strm_ready_start_i=1, then go to W_RESP.
- W_RESP:
  - wr_rsp_valid_o=1, with id=latched id and err=err flag. Hold until wr_rsp_ready_i, then go to IDLE.
  - Total latency: last beat to rsp_valid ≥ 2 cycles.
- R_DATA:
  - rd_data_valid_o=strm_i_valid and strm_i_ready=rd_data_ready_i. Data passes through. id = latched id.
  - rd_data_last_o=1 while counter==len.
  - The final handshake goes to R_DRAIN. strm_i_ready=0 in every other state.
- R_DRAIN: wait for rd_strm_ready_start_i=1, then go to IDLE.
- Counter width is LEN_W+1, so it never wraps within a burst.
- len=0 is a single beat: last is asserted on the first beat.
- A new request is never accepted until the previous response or final beat has been handshaken.
- clear_i mid-burst: return to IDLE next cycle, drop the in-flight burst, emit no response.

Optional Feature:
NVDLA_DBB_BRIDGE_LAST_CHECK_EN
- Defined:
  - On each write beat, compare wr_last_i with (counter==len). Any mismatch sets a sticky err flag, cleared on the next accepted request.
  - wr_rsp_err_o = err flag.
  - The burst still completes on the beat count.
- Undefined: wr_last_i is ignored and wr_rsp_err_o is tied to 0.

Test Plan:
- Write addr=0x100, len=3, id=0x5A, streamer idle, 4 beats with last on the 4th -> one start pulse with base=0x100 and size=4; 4 beats on strm_o; wr_rsp id=0x5A, err=0.
- Read addr=0x200, len=0, id=0x11 -> size=1; one rd_data beat with last=1, id=0x11; back to IDLE after ready_start.
- Write and read valid in the same cycle twice in a row, after reset -> write granted first, read second.
- Write len=1 with wr_last_i on beat 0 (macro on) -> wr_rsp_err_o=1. Same stimulus with macro off -> err=0.
- rd_data_ready_i toggled 0/1 during a len=7 read -> exactly 8 beats, no loss or duplication; last only on the 8th beat.
- clear_i asserted after beat 2 of a len=5 write -> IDLE next cycle, no wr_rsp; a following read completes normally.
